// File: rtl/conv_1x1_pw_pkg.sv
// Shared definitions for the pointwise convolution block: post-op mode
// codes, config register addresses, frame position flags and the
// accumulator width derivation.
package conv_pkg;

    localparam logic [1:0] MODE_PASS = 2'd0;
    localparam logic [1:0] MODE_ABS  = 2'd1;
    localparam logic [1:0] MODE_RELU = 2'd2;

    localparam logic [3:0] CFG_BIAS  = 4'd8;
    localparam logic [3:0] CFG_SHIFT = 4'd9;
    localparam logic [3:0] CFG_MODE  = 4'd10;

    // Position of a pixel inside its frame, carried alongside the data.
    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } pos_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Accumulator width: signed product, growth of the C-term sum, one
    // spare bit so the bias add cannot overflow.
    function automatic int acc_width(input int pw, input int kw, input int c);
        return pw + kw + 1 + clog2(c) + 1;
    endfunction

endpackage

// File: rtl/conv_1x1_pw_if.sv
// Pixel stream, config write port and frame status of conv_1x1_pw.
// master = pixel source / config host, slave = the convolution block.
interface conv_1x1_pw_if #(
    parameter int C  = 3,
    parameter int PW = 8
);
    logic              in_valid;
    logic [C*PW-1:0]   pxl_in;
    logic              cfg_we;
    logic [3:0]        cfg_addr;
    logic [15:0]       cfg_data;
    logic              out_valid;
    logic [PW-1:0]     pxl_out;
    logic              out_sof;
    logic              out_eol;
    logic              out_eof;
    logic              busy;

    modport master (
        output in_valid, pxl_in, cfg_we, cfg_addr, cfg_data,
        input  out_valid, pxl_out, out_sof, out_eol, out_eof, busy
    );

    modport slave (
        input  in_valid, pxl_in, cfg_we, cfg_addr, cfg_data,
        output out_valid, pxl_out, out_sof, out_eol, out_eof, busy
    );
endinterface

// File: rtl/conv_post_op.sv
// Combinational back end of the convolution: arithmetic right shift
// (optionally rounded), post-op by mode, saturation to an unsigned pixel.
// Build option: define CONV_1X1_PW_ROUND_EN to add 2^(shift-1) before the
// shift (round half up); otherwise the shift truncates toward -inf.
module conv_post_op
    import conv_pkg::*;
#(
    parameter int PW    = 8,
    parameter int ACC_W = 20
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic        [3:0]       shift,
    input  logic        [1:0]       mode,
    output logic        [PW-1:0]    pixel
);

    // Two extra bits: one for the rounding add, one so negating the most
    // negative accumulator value stays positive.
    localparam int EXT_W = ACC_W + 2;
    localparam logic signed [EXT_W-1:0] PIX_MAX = EXT_W'((1 << PW) - 1);

    function automatic logic signed [EXT_W-1:0] round_shift(
        input logic signed [ACC_W-1:0] a,
        input logic        [3:0]       sh
    );
        logic signed [EXT_W-1:0] v;
        v = EXT_W'(a);
`ifdef CONV_1X1_PW_ROUND_EN
        if (sh != 4'd0) v = v + (EXT_W'(1) <<< (sh - 4'd1));
`endif
        return v >>> sh;
    endfunction

    function automatic logic [PW-1:0] sat_pixel(
        input logic signed [EXT_W-1:0] v,
        input logic        [1:0]       md
    );
        logic signed [EXT_W-1:0] m;
        logic        [PW-1:0]    r;
        m = v;
        if (v[EXT_W-1]) begin
            // Mode 3 is treated like ABS.
            if (md == MODE_PASS || md == MODE_RELU) m = '0;
            else                                    m = -v;
        end
        if (m > PIX_MAX) r = '1;
        else             r = m[PW-1:0];
        return r;
    endfunction

    // Shift, post-op and clamp in one combinational step.
    always_comb begin
        pixel = sat_pixel(round_shift(acc, shift), mode);
    end

endmodule

// File: rtl/conv_1x1_pw.sv
// Pointwise (1x1) convolution over C channels with a 3-stage pipeline:
//   S1 products, S2 adder tree + bias, S3 shift/post-op/saturate.
// Config is double-banked: host writes land in a shadow bank that is
// copied to the active bank when the first pixel of a frame is accepted.
// Build option: CONV_1X1_PW_ROUND_EN enables rounding before the shift.
module conv_1x1_pw
    import conv_pkg::*;
#(
    parameter int C  = 3,
    parameter int PW = 8,
    parameter int KW = 8,
    parameter int BW = 16,
    parameter int W  = 220,
    parameter int H  = 220
) (
    input logic           clk,
    input logic           reset,
    conv_1x1_pw_if.slave  bus
);

    localparam int ACC_W  = acc_width(PW, KW, C);
    localparam int PROD_W = PW + 1 + KW;
    localparam int COL_W  = (clog2(W) > 0) ? clog2(W) : 1;
    localparam int ROW_W  = (clog2(H) > 0) ? clog2(H) : 1;

    function automatic logic signed [KW-1:0] wt_default(input int i);
        return (i == 0) ? '1 : '0;
    endfunction

    // Config banks
    logic signed [KW-1:0] wt_sh  [C];
    logic signed [KW-1:0] wt_act [C];
    logic signed [KW-1:0] wt_use [C];
    logic signed [BW-1:0] bias_sh, bias_act, bias_use;
    logic        [3:0]    shift_sh, shift_act, shift_use;
    logic        [1:0]    mode_sh, mode_act, mode_use;

    // Frame position
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             busy;
    logic             first;
    pos_t             pos_s0;

    // Pipeline
    logic signed [PROD_W-1:0] prod_p1 [C];
    logic signed [BW-1:0]     bias_p1;
    logic        [3:0]        shift_p1, shift_p2;
    logic        [1:0]        mode_p1, mode_p2;
    pos_t                     pos_p1, pos_p2, pos_p3;
    logic                     vld_p1, vld_p2, vld_p3;
    logic signed [ACC_W-1:0]  acc_sum, acc_p2;
    logic        [PW-1:0]     pix_s3, pix_p3;

    assign first = bus.in_valid && (col == '0) && (row == '0) && !busy;

    // Frame position flags of the pixel currently on pxl_in.
    always_comb begin
        pos_s0.sof = (col == '0) && (row == '0);
        pos_s0.eol = (col == COL_W'(W - 1));
        pos_s0.eof = (col == COL_W'(W - 1)) && (row == ROW_W'(H - 1));
    end

    // Host writes into the shadow bank.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < C; i++) wt_sh[i] <= wt_default(i);
            bias_sh  <= '0;
            shift_sh <= '0;
            mode_sh  <= MODE_ABS;
        end else if (bus.cfg_we) begin
            for (int i = 0; i < C; i++) begin
                if (bus.cfg_addr == 4'(i)) wt_sh[i] <= bus.cfg_data[KW-1:0];
            end
            if (bus.cfg_addr == CFG_BIAS)  bias_sh  <= bus.cfg_data[BW-1:0];
            if (bus.cfg_addr == CFG_SHIFT) shift_sh <= bus.cfg_data[3:0];
            if (bus.cfg_addr == CFG_MODE)  mode_sh  <= bus.cfg_data[1:0];
        end
    end

    // Active bank follows the shadow bank only at frame start.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < C; i++) wt_act[i] <= wt_default(i);
            bias_act  <= '0;
            shift_act <= '0;
            mode_act  <= MODE_ABS;
        end else if (first) begin
            for (int i = 0; i < C; i++) wt_act[i] <= wt_sh[i];
            bias_act  <= bias_sh;
            shift_act <= shift_sh;
            mode_act  <= mode_sh;
        end
    end

    // The first pixel of a frame must already see the bank being loaded.
    always_comb begin
        for (int i = 0; i < C; i++) wt_use[i] = first ? wt_sh[i] : wt_act[i];
        bias_use  = first ? bias_sh  : bias_act;
        shift_use = first ? shift_sh : shift_act;
        mode_use  = first ? mode_sh  : mode_act;
    end

    // Column/row counters and busy advance only on accepted pixels.
    always_ff @(posedge clk) begin
        if (reset) begin
            col  <= '0;
            row  <= '0;
            busy <= 1'b0;
        end else if (bus.in_valid) begin
            if (pos_s0.eol) begin
                col <= '0;
                row <= pos_s0.eof ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
            busy <= !pos_s0.eof;
        end
    end

    // ---- S1: channel products; per-pixel config travels with the data ----
    always_ff @(posedge clk) begin
        for (int i = 0; i < C; i++) begin
            prod_p1[i] <= PROD_W'($signed({1'b0, bus.pxl_in[i*PW +: PW]}))
                        * PROD_W'(wt_use[i]);
        end
        bias_p1  <= bias_use;
        shift_p1 <= shift_use;
        mode_p1  <= mode_use;
        pos_p1   <= pos_s0;
    end

    // S1 valid.
    always_ff @(posedge clk) begin
        if (reset) vld_p1 <= 1'b0;
        else       vld_p1 <= bus.in_valid;
    end

    // Adder tree over the C products plus sign-extended bias.
    always_comb begin
        acc_sum = ACC_W'(bias_p1);
        for (int i = 0; i < C; i++) acc_sum = acc_sum + ACC_W'(prod_p1[i]);
    end

    // ---- S2: accumulated sum ----
    always_ff @(posedge clk) begin
        acc_p2   <= acc_sum;
        shift_p2 <= shift_p1;
        mode_p2  <= mode_p1;
        pos_p2   <= pos_p1;
    end

    // S2 valid.
    always_ff @(posedge clk) begin
        if (reset) vld_p2 <= 1'b0;
        else       vld_p2 <= vld_p1;
    end

    conv_post_op #(
        .PW    (PW),
        .ACC_W (ACC_W)
    ) u_post_op (
        .acc   (acc_p2),
        .shift (shift_p2),
        .mode  (mode_p2),
        .pixel (pix_s3)
    );

    // ---- S3: output register; flags only ever high with a valid pixel ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p3 <= 1'b0;
            pix_p3 <= '0;
            pos_p3 <= '0;
        end else begin
            vld_p3 <= vld_p2;
            pix_p3 <= pix_s3;
            pos_p3 <= vld_p2 ? pos_p2 : '0;
        end
    end

    assign bus.out_valid = vld_p3;
    assign bus.pxl_out   = pix_p3;
    assign bus.out_sof   = pos_p3.sof;
    assign bus.out_eol   = pos_p3.eol;
    assign bus.out_eof   = pos_p3.eof;
    assign bus.busy      = busy;

endmodule

// File: tb/tb_conv_1x1_pw.sv
// Directed bench for conv_1x1_pw: a C=3 and a C=1 instance share one
// stimulus stream on a 4x2 frame. Expected pixels are hand-computed; the
// CONV_1X1_PW_ROUND_EN build selects the rounded expectations.
module tb_conv_1x1_pw;
    import conv_pkg::*;

    typedef struct packed {
        logic [7:0] pix;
        logic       sof;
        logic       eol;
        logic       eof;
    } obs_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    conv_1x1_pw_if #(.C(3), .PW(8)) bus3 ();
    conv_1x1_pw_if #(.C(1), .PW(8)) bus1 ();

    assign bus1.in_valid = bus3.in_valid;
    assign bus1.pxl_in   = bus3.pxl_in[7:0];
    assign bus1.cfg_we   = bus3.cfg_we;
    assign bus1.cfg_addr = bus3.cfg_addr;
    assign bus1.cfg_data = bus3.cfg_data;

    conv_1x1_pw #(.C(3), .PW(8), .KW(8), .BW(16), .W(4), .H(2)) u_c3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3.slave)
    );

    conv_1x1_pw #(.C(1), .PW(8), .KW(8), .BW(16), .W(4), .H(2)) u_c1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    // Output capture
    obs_t obs3 [512];
    obs_t obs1 [512];
    int   n3 = 0;
    int   n1 = 0;

    always @(negedge clk) begin
        if (bus3.out_valid === 1'b1) begin
            obs3[n3] <= '{bus3.pxl_out, bus3.out_sof, bus3.out_eol, bus3.out_eof};
            n3 <= n3 + 1;
        end
        if (bus1.out_valid === 1'b1) begin
            obs1[n1] <= '{bus1.pxl_out, bus1.out_sof, bus1.out_eol, bus1.out_eof};
            n1 <= n1 + 1;
        end
    end

    // in_valid history: out_valid must equal in_valid from three cycles back
    logic [2:0] vhist = 3'b000;
    bit         lat_en = 1'b0;
    int         lat_bad = 0;

    always @(posedge clk) begin
        vhist <= reset ? 3'b000 : {vhist[1:0], bus3.in_valid};
    end

    always @(negedge clk) begin
        if (lat_en) begin
            if (bus3.out_valid !== vhist[2] || bus1.out_valid !== vhist[2])
                lat_bad++;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [3:0] a, input logic [15:0] d);
        bus3.cfg_we   = 1'b1;
        bus3.cfg_addr = a;
        bus3.cfg_data = d;
        tick();
        bus3.cfg_we   = 1'b0;
    endtask

    task automatic push(input logic [23:0] p);
        bus3.in_valid = 1'b1;
        bus3.pxl_in   = p;
        tick();
        bus3.in_valid = 1'b0;
    endtask

    // One 8-pixel frame with random gaps; ch0 from the table, ch1/ch2 filler
    // (or the given values when full is set). Optional weight0 write after
    // pixel index wr_at.
    task automatic send_frame(input string tag, input logic [23:0] px [8], input int wr_at);
        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            push(px[k]);
            check($sformatf("%s_busy%0d", tag, k), 32'(bus3.busy), 32'(k < 7));
            if (k == wr_at) cfg(4'd0, 16'd2);
        end
    endtask

    task automatic expect_frame(input string tag, input int base, input logic [7:0] ex [8]);
        logic [2:0] fl;
        repeat (6) tick();
        check({tag, "_count"}, 32'(n3 - base), 32'd8);
        for (int k = 0; k < 8; k++) begin
            fl = {k == 0, k == 3 || k == 7, k == 7};
            check($sformatf("%s_pix%0d", tag, k), 32'(obs3[base+k].pix), 32'(ex[k]));
            check($sformatf("%s_flags%0d", tag, k),
                  32'({obs3[base+k].sof, obs3[base+k].eol, obs3[base+k].eof}), 32'(fl));
        end
    endtask

    // Build a frame from per-channel tables.
    function automatic void mk(output logic [23:0] px [8],
                               input logic [7:0] c0 [8], input logic [7:0] c1 [8],
                               input logic [7:0] c2 [8]);
        for (int k = 0; k < 8; k++) px[k] = {c2[k], c1[k], c0[k]};
    endfunction

    logic [23:0] px [8];
    logic [7:0]  z8 [8]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    logic [7:0]  f1 [8]  = '{9, 33, 77, 1, 250, 18, 64, 5};
    logic [7:0]  f2 [8]  = '{200, 3, 90, 17, 8, 111, 6, 42};
    int b3, b1;

    initial begin
        bus3.in_valid = 1'b0;
        bus3.pxl_in   = '0;
        bus3.cfg_we   = 1'b0;
        bus3.cfg_addr = '0;
        bus3.cfg_data = '0;

        repeat (3) tick();
        check("rst_out_valid", 32'({bus3.out_valid, bus1.out_valid}), 32'd0);
        check("rst_pxl_out",   32'({bus3.pxl_out, bus1.pxl_out}), 32'd0);
        check("rst_flags",     32'({bus3.out_sof, bus3.out_eol, bus3.out_eof,
                                    bus1.out_sof, bus1.out_eol, bus1.out_eof}), 32'd0);
        check("rst_busy",      32'({bus3.busy, bus1.busy}), 32'd0);
        reset = 1'b0;
        lat_en = 1'b1;

        // Defaults (weight0=-1, ABS) reproduce the input on channel 0.
        b3 = n3; b1 = n1;
        mk(px, '{100, 0, 7, 255, 1, 50, 200, 3}, f1, f2);
        send_frame("dflt", px, -1);
        expect_frame("dflt_c3", b3, '{100, 0, 7, 255, 1, 50, 200, 3});
        check("dflt_c1_count", 32'(n1 - b1), 32'd8);
        check("dflt_c1_pix0", 32'(obs1[b1].pix),   32'd100);
        check("dflt_c1_pix1", 32'(obs1[b1+1].pix), 32'd0);
        check("dflt_c1_pix3", 32'(obs1[b1+3].pix), 32'd255);
        check("dflt_c1_eof7", 32'({obs1[b1+7].sof, obs1[b1+7].eol, obs1[b1+7].eof}), 32'd3);

        // weights {4,0,0}, PASS
        cfg(4'd0, 16'd4);
        cfg(CFG_MODE, 16'(MODE_PASS));
        b3 = n3;
        mk(px, '{200, 10, 63, 64, 0, 1, 100, 255}, f1, f2);
        send_frame("w4", px, -1);
        expect_frame("w4", b3, '{255, 40, 252, 255, 0, 4, 255, 255});

        // weights {1,1,1}, bias -300, PASS
        cfg(4'd0, 16'd1);
        cfg(4'd1, 16'd1);
        cfg(4'd2, 16'd1);
        cfg(CFG_BIAS, 16'hFED4);
        b3 = n3;
        mk(px, '{10, 100, 255, 200, 0, 101, 45, 46},
               '{20, 100, 255, 100, 0, 100, 255, 255},
               '{30, 100, 255,  50, 0, 100, 255, 255});
        send_frame("bias_pass", px, -1);
        expect_frame("bias_pass", b3, '{0, 0, 255, 50, 0, 1, 255, 255});

        // same data, ABS
        cfg(CFG_MODE, 16'(MODE_ABS));
        b3 = n3;
        send_frame("bias_abs", px, -1);
        expect_frame("bias_abs", b3, '{240, 0, 255, 50, 255, 1, 255, 255});

        // mode 3 behaves as ABS
        cfg(CFG_MODE, 16'd3);
        b3 = n3;
        send_frame("bias_m3", px, -1);
        expect_frame("bias_m3", b3, '{240, 0, 255, 50, 255, 1, 255, 255});

        // RELU, shift 2, weight0 = -3
        cfg(CFG_MODE, 16'(MODE_RELU));
        cfg(CFG_SHIFT, 16'd2);
        cfg(CFG_BIAS, 16'd0);
        cfg(4'd0, 16'h00FD);
        cfg(4'd1, 16'd0);
        cfg(4'd2, 16'd0);
        b3 = n3;
        mk(px, '{50, 0, 255, 1, 7, 100, 200, 3}, f1, f2);
        send_frame("relu_neg", px, -1);
        expect_frame("relu_neg", b3, '{0, 0, 0, 0, 0, 0, 0, 0});

        // weight0 = 3: shifted positive results
        cfg(4'd0, 16'd3);
        b3 = n3;
        mk(px, '{50, 4, 6, 255, 100, 0, 1, 2}, f1, f2);
        send_frame("relu_shift", px, -1);
`ifdef CONV_1X1_PW_ROUND_EN
        expect_frame("relu_shift", b3, '{38, 3, 5, 191, 75, 0, 1, 2});
`else
        expect_frame("relu_shift", b3, '{37, 3, 4, 191, 75, 0, 0, 1});
`endif

        // weight 1, PASS, no shift; weight0=2 written mid-frame
        cfg(4'd0, 16'd1);
        cfg(CFG_SHIFT, 16'd0);
        cfg(CFG_MODE, 16'(MODE_PASS));
        b3 = n3;
        mk(px, '{5, 6, 7, 8, 9, 10, 11, 12}, z8, z8);
        send_frame("midwr", px, 2);
        expect_frame("midwr", b3, '{5, 6, 7, 8, 9, 10, 11, 12});

        b3 = n3;
        mk(px, '{10, 20, 30, 40, 50, 100, 127, 128}, f1, f2);
        send_frame("nextfr", px, -1);
        expect_frame("nextfr", b3, '{20, 40, 60, 80, 100, 200, 254, 255});

        // Reset during pixel 5 of a back-to-back frame.
        b3 = n3;
        push(24'd5);
        push(24'd6);
        push(24'd7);
        push(24'd8);
        bus3.in_valid = 1'b1;
        bus3.pxl_in   = 24'd9;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus3.in_valid = 1'b0;
        repeat (6) tick();
        check("rstmid_count", 32'(n3 - b3), 32'd2);
        check("rstmid_pix0",  32'(obs3[b3].pix),   32'd10);
        check("rstmid_pix1",  32'(obs3[b3+1].pix), 32'd12);
        check("rstmid_busy",  32'(bus3.busy), 32'd0);

        b3 = n3; b1 = n1;
        push({8'd40, 8'd30, 8'd10});
        repeat (5) tick();
        check("after_rst_count", 32'(n3 - b3), 32'd1);
        check("after_rst_pix",   32'(obs3[b3].pix), 32'd10);
        check("after_rst_flags", 32'({obs3[b3].sof, obs3[b3].eol, obs3[b3].eof}), 32'd4);
        check("after_rst_c1",    32'(obs1[b1].pix), 32'd10);
        check("after_rst_busy",  32'(bus3.busy), 32'd1);

        check("out_valid_latency", 32'(lat_bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
